// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide execute unit.
package muldiv_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned ITERATIONS = 32;
    localparam int unsigned CNT_W      = $clog2(ITERATIONS);
    localparam int unsigned ACC_W      = 2 * XLEN + 1;
    localparam int unsigned TAG_W      = 5;

    localparam logic [XLEN-1:0] DIV_BY_ZERO_LO = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Destination tag carried alongside an operation.
    typedef struct packed {
        logic [TAG_W-1:0] regdest;
        logic             writereg;
    } tag_t;

    function automatic logic op_is_div(input op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input op_e op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    // Apply sign correction to an unsigned magnitude result {HI, LO}.
    function automatic logic [2*XLEN-1:0] finalize(
        input logic              is_div,
        input logic              neg_a,
        input logic              neg_b,
        input logic              b_zero,
        input logic [2*XLEN-1:0] raw
    );
        logic [2*XLEN-1:0] res;
        logic [XLEN-1:0]   hi;
        logic [XLEN-1:0]   lo;
        hi = raw[2*XLEN-1:XLEN];
        lo = raw[XLEN-1:0];
        if (is_div) begin
            if (neg_a ^ neg_b) lo = -lo;
            // Remainder follows the dividend; with a zero divisor this yields the dividend itself.
            if (neg_a) hi = -hi;
            if (b_zero) lo = DIV_BY_ZERO_LO;
            res = {hi, lo};
        end else begin
            res = (neg_a ^ neg_b) ? -raw : raw;
        end
        return res;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide.
// Accumulator layout for both: [64:32] partial high/remainder, [31:0] multiplier/quotient bits.
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic             is_div,
    input  logic [XLEN-1:0]  operand,
    input  logic [ACC_W-1:0] acc_in,
    output logic [ACC_W-1:0] acc_next_c
);

    logic [XLEN:0]   sum_c;
    logic [XLEN+1:0] rem_sh_c;
    logic [XLEN:0]   trial_c;
    logic            fits_c;

    // Single step of either algorithm, selected by is_div.
    always_comb begin
        sum_c    = {1'b0, acc_in[2*XLEN-1:XLEN]} + (acc_in[0] ? {1'b0, operand} : '0);
        rem_sh_c = acc_in[ACC_W-1:XLEN-1];
        fits_c   = rem_sh_c >= (XLEN+2)'(operand);
        trial_c  = rem_sh_c[XLEN:0] - {1'b0, operand};
        if (is_div) begin
            acc_next_c = {(fits_c ? trial_c : rem_sh_c[XLEN:0]), acc_in[XLEN-2:0], fits_c};
        end else begin
            acc_next_c = {1'b0, sum_c, acc_in[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/execute_muldiv.sv
// Execute-stage multiply/divide unit: 33-cycle iterative MULT/MULTU/DIV/DIVU.
// Optional macro EXECUTE_MULDIV_FAST_MUL_EN: single-cycle combinational multiply path.
module execute_muldiv
    import muldiv_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [1:0]  in_op,
    input  logic [31:0] in_rs,
    input  logic [31:0] in_rt,
    input  logic [4:0]  in_regdest,
    input  logic        in_writereg,
    output logic        out_busy,
    output logic        out_valid,
    output logic [4:0]  out_regdest,
    output logic        out_writereg,
    output logic [31:0] out_wbvalue,
    output logic [31:0] out_hivalue
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    op_e               op_q, op_d;
    tag_t              tag_q, tag_d;
    logic              neg_a_q, neg_a_d;
    logic              neg_b_q, neg_b_d;
    logic [XLEN-1:0]   operand_q, operand_d;
    logic [ACC_W-1:0]  acc_q, acc_d;

    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              writereg_q, writereg_d;
    logic [TAG_W-1:0]  regdest_q, regdest_d;
    logic [XLEN-1:0]   wbvalue_q, wbvalue_d;
    logic [XLEN-1:0]   hivalue_q, hivalue_d;

    op_e               in_op_c;
    logic              in_div_c;
    logic              a_neg_c, b_neg_c;
    logic [XLEN-1:0]   a_mag_c, b_mag_c;
    logic              run_div_c;
    logic [ACC_W-1:0]  step_acc_c;
    logic [2*XLEN-1:0] result_c;

    // Decode the incoming request into magnitudes and operand signs.
    always_comb begin
        in_op_c   = op_e'(in_op);
        in_div_c  = op_is_div(in_op_c);
        a_neg_c   = op_is_signed(in_op_c) & in_rs[XLEN-1];
        b_neg_c   = op_is_signed(in_op_c) & in_rt[XLEN-1];
        a_mag_c   = a_neg_c ? -in_rs : in_rs;
        b_mag_c   = b_neg_c ? -in_rt : in_rt;
        run_div_c = op_is_div(op_q);
    end

    muldiv_step u_step (
        .is_div     (run_div_c),
        .operand    (operand_q),
        .acc_in     (acc_q),
        .acc_next_c (step_acc_c)
    );

    // Next-state, datapath load and output register update.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        op_d       = op_q;
        tag_d      = tag_q;
        neg_a_d    = neg_a_q;
        neg_b_d    = neg_b_q;
        operand_d  = operand_q;
        acc_d      = acc_q;
        result_c   = '0;
        valid_d    = 1'b0;
        writereg_d = 1'b0;
        regdest_d  = regdest_q;
        wbvalue_d  = wbvalue_q;
        hivalue_d  = hivalue_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d      = in_op_c;
                    tag_d     = '{regdest: in_regdest, writereg: in_writereg};
                    neg_a_d   = a_neg_c;
                    neg_b_d   = b_neg_c;
                    operand_d = in_div_c ? b_mag_c : a_mag_c;
                    acc_d     = {(XLEN+1)'(0), (in_div_c ? a_mag_c : b_mag_c)};
                    count_d   = '0;
                    state_d   = S_RUN;
`ifdef EXECUTE_MULDIV_FAST_MUL_EN
                    if (!in_div_c) begin
                        state_d  = S_DONE;
                        result_c = finalize(1'b0, a_neg_c, b_neg_c, 1'b0,
                                            (2*XLEN)'(a_mag_c) * (2*XLEN)'(b_mag_c));
                    end
`endif
                end
            end
            S_RUN: begin
                acc_d   = step_acc_c;
                count_d = count_q + CNT_W'(1);
                if (count_q == CNT_W'(ITERATIONS - 1)) begin
                    state_d  = S_DONE;
                    result_c = finalize(run_div_c, neg_a_q, neg_b_q, operand_q == '0,
                                        step_acc_c[2*XLEN-1:0]);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_DONE) begin
            valid_d    = 1'b1;
            writereg_d = tag_d.writereg;
            regdest_d  = tag_d.regdest;
            wbvalue_d  = result_c[XLEN-1:0];
            hivalue_d  = result_c[2*XLEN-1:XLEN];
        end
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            op_q       <= OP_MULT;
            tag_q      <= '0;
            neg_a_q    <= 1'b0;
            neg_b_q    <= 1'b0;
            operand_q  <= '0;
            acc_q      <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            writereg_q <= 1'b0;
            regdest_q  <= '0;
            wbvalue_q  <= '0;
            hivalue_q  <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            op_q       <= op_d;
            tag_q      <= tag_d;
            neg_a_q    <= neg_a_d;
            neg_b_q    <= neg_b_d;
            operand_q  <= operand_d;
            acc_q      <= acc_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            writereg_q <= writereg_d;
            regdest_q  <= regdest_d;
            wbvalue_q  <= wbvalue_d;
            hivalue_q  <= hivalue_d;
        end
    end

    assign out_busy     = busy_q;
    assign out_valid    = valid_q;
    assign out_regdest  = regdest_q;
    assign out_writereg = writereg_q;
    assign out_wbvalue  = wbvalue_q;
    assign out_hivalue  = hivalue_q;

endmodule

// File: tb/tb_execute_muldiv.sv
// Bench for execute_muldiv: directed vectors, random ops against an arithmetic model,
// and abort/ignore sequences. Honours EXECUTE_MULDIV_FAST_MUL_EN for multiply latency.
module tb_execute_muldiv;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [1:0]  in_op = 2'd0;
    logic [31:0] in_rs = 32'd0;
    logic [31:0] in_rt = 32'd0;
    logic [4:0]  in_regdest = 5'd0;
    logic        in_writereg = 1'b0;
    logic        out_busy;
    logic        out_valid;
    logic [4:0]  out_regdest;
    logic        out_writereg;
    logic [31:0] out_wbvalue;
    logic [31:0] out_hivalue;

    int checks = 0;
    int errors = 0;

    execute_muldiv dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_op        (in_op),
        .in_rs        (in_rs),
        .in_rt        (in_rt),
        .in_regdest   (in_regdest),
        .in_writereg  (in_writereg),
        .out_busy     (out_busy),
        .out_valid    (out_valid),
        .out_regdest  (out_regdest),
        .out_writereg (out_writereg),
        .out_wbvalue  (out_wbvalue),
        .out_hivalue  (out_hivalue)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        wr;
        logic [31:0] lo;
        logic [31:0] hi;
    } vec_t;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic int latency(input logic [1:0] op);
`ifdef EXECUTE_MULDIV_FAST_MUL_EN
        return (op < 2'd2) ? 1 : 33;
`else
        return 33;
`endif
    endfunction

    // Reference: plain SystemVerilog arithmetic, returns {HI, LO}.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p;
        int     q, r;
        logic [63:0] res;
        case (op)
            2'd0: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                p = sa * sb;
                res = 64'(p);
            end
            2'd1: res = {32'd0, a} * {32'd0, b};
            2'd2: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = {32'd0, 32'h8000_0000};
                else begin
                    q = $signed(a) / $signed(b);
                    r = $signed(a) % $signed(b);
                    res = {32'(r), 32'(q)};
                end
            end
            default: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else res = {a % b, a / b};
            end
        endcase
        return res;
    endfunction

    // Issue one op from an idle negedge, wait for the strobe, check result, timing and hold.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic wr, input logic [63:0] exp, input string name);
        int   k;
        logic seen;
        for (int w = 0; w < 100 && out_busy; w++) @(negedge clock);
        in_valid = 1'b1; in_op = op; in_rs = a; in_rt = b; in_regdest = rd; in_writereg = wr;
        @(negedge clock);
        in_valid = 1'b0;
        in_op = 2'($urandom); in_rs = $urandom; in_rt = $urandom;
        in_regdest = 5'($urandom); in_writereg = 1'($urandom);
        seen = 1'b0;
        k = 1;
        while (k <= 60) begin
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            if (k == 1) check({name, "_busy_run"}, 64'(out_busy), 64'd1);
            @(negedge clock);
            k++;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout got=no_out_valid exp=out_valid", name);
        end else begin
            check({name, "_latency"}, 64'(k), 64'(latency(op)));
            check({name, "_result"}, {out_hivalue, out_wbvalue}, exp);
            check({name, "_tag"}, 64'({out_regdest, out_writereg}), 64'({rd, wr}));
            check({name, "_busy_done"}, 64'(out_busy), 64'd1);
            @(negedge clock);
            check({name, "_after_ctl"}, 64'({out_valid, out_writereg, out_busy}), 64'd0);
            check({name, "_hold"}, {out_hivalue, out_wbvalue}, exp);
            check({name, "_hold_rd"}, 64'(out_regdest), 64'(rd));
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'd1;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        vec_t tbl[10];
        int   pulses;
        logic [63:0] cap;
        logic [1:0]  rop;
        logic [31:0] ra, rb;

        tbl[0] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1,  1'b0, 32'h0000_0001, 32'hFFFF_FFFE};
        tbl[1] = '{2'd0, 32'hFFFF_FFFD, 32'h0000_0005, 5'd9,  1'b1, 32'hFFFF_FFF1, 32'hFFFF_FFFF};
        tbl[2] = '{2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 5'd3,  1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
        tbl[3] = '{2'd3, 32'h0000_000A, 32'h0000_0000, 5'd4,  1'b0, 32'hFFFF_FFFF, 32'h0000_000A};
        tbl[4] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd5,  1'b1, 32'h8000_0000, 32'h0000_0000};
        tbl[5] = '{2'd1, 32'd7,         32'd6,         5'd6,  1'b1, 32'd42,        32'd0};
        tbl[6] = '{2'd3, 32'd42,        32'd6,         5'd7,  1'b0, 32'd7,         32'd0};
        tbl[7] = '{2'd2, 32'd7,         32'hFFFF_FFFE, 5'd8,  1'b1, 32'hFFFF_FFFD, 32'd1};
        tbl[8] = '{2'd2, 32'hFFFF_FFF0, 32'd0,         5'd31, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF0};
        tbl[9] = '{2'd0, 32'h8000_0000, 32'h8000_0000, 5'd17, 1'b0, 32'h0000_0000, 32'h4000_0000};

        // Reset held with a simultaneous request: reset must win.
        in_valid = 1'b1; in_op = 2'd1; in_rs = 32'd5; in_rt = 32'd5;
        in_regdest = 5'd2; in_writereg = 1'b1;
        repeat (3) @(negedge clock);
        check("reset_ctl", 64'({out_busy, out_valid, out_writereg, out_regdest}), 64'd0);
        check("reset_data", {out_hivalue, out_wbvalue}, 64'd0);
        reset = 1'b0;
        in_valid = 1'b0;
        @(negedge clock);
        check("post_reset_idle", 64'({out_busy, out_valid}), 64'd0);

        // Directed vectors.
        for (int i = 0; i < 10; i++) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].rd, tbl[i].wr,
                   {tbl[i].hi, tbl[i].lo}, $sformatf("vec%0d", i));
        end

        // Randomized ops against the model.
        for (int i = 0; i < 30; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra = pick();
            rb = pick();
            run_op(rop, ra, rb, 5'($urandom), 1'($urandom), model(rop, ra, rb),
                   $sformatf("rnd%0d_op%0d", i, rop));
        end

        // Second request during RUN is ignored.
        in_valid = 1'b1; in_op = 2'd3; in_rs = 32'd100; in_rt = 32'd7;
        in_regdest = 5'd12; in_writereg = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        repeat (4) @(negedge clock);
        in_valid = 1'b1; in_op = 2'd1; in_rs = 32'd3; in_rt = 32'd3; in_regdest = 5'd20;
        @(negedge clock);
        in_valid = 1'b0;
        pulses = 0;
        cap = '0;
        for (int c = 0; c < 80; c++) begin
            if (out_valid) begin
                pulses++;
                cap = {out_hivalue, out_wbvalue};
            end
            @(negedge clock);
        end
        check("ignore_pulses", 64'(pulses), 64'd1);
        check("ignore_result", cap, {32'd2, 32'd14});

        // Reset on iteration 10 aborts with no strobe.
        run_op(2'd1, 32'd5, 32'd7, 5'd3, 1'b1, 64'd35, "pre_abort");
        in_valid = 1'b1; in_op = 2'd3; in_rs = 32'hFFFF_FFFF; in_rt = 32'd3;
        in_regdest = 5'd11; in_writereg = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        repeat (10) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("abort_ctl", 64'({out_busy, out_valid, out_writereg, out_regdest}), 64'd0);
        check("abort_data", {out_hivalue, out_wbvalue}, 64'd0);
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            if (out_valid || out_busy) pulses++;
            @(negedge clock);
        end
        check("abort_no_valid", 64'(pulses), 64'd0);

        // Unit still works after the abort.
        run_op(2'd3, 32'd42, 32'd6, 5'd1, 1'b1, {32'd0, 32'd7}, "post_abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
